// File: rtl/cart_rom_port.sv
// cart_rom_port
// Final stage of the cartridge mapper. It turns the level-style ROM strobes
// into single requests on a toggle-handshake SDRAM channel, and it returns
// read data with a ready flag. A one-word read cache serves repeated reads
// of the same word without SDRAM traffic. A read or write that arrives while
// a request is in flight is held in a one-deep slot. It is serviced when the
// FSM returns to IDLE, and a held write is serviced before a held read.

module cart_rom_port #(
  parameter logic [24:0] BASE_ADDR = 25'h0000000,
  parameter bit          WR_EN     = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [22:0] ROM_A,
  input  logic [15:0] ROM_DO,
  input  logic        ROM_RD,
  input  logic        ROM_WRL,
  input  logic        ROM_WRH,
  output logic [15:0] ROM_DI,
  output logic        ROM_RDY,
  output logic        ROM_WACK,
  output logic [23:0] MEM_ADDR,
  output logic [15:0] MEM_DO,
  output logic [1:0]  MEM_BE,
  output logic        MEM_WE,
  output logic        MEM_REQ,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_DI
);

  // Word-granular base: the byte-lane bit of BASE_ADDR has no meaning here.
  localparam logic [23:0] BASE_WORD = BASE_ADDR[24:1];

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2
  } state_t;

  // Bus history used for edge/event detection.
  logic        r_rd_q;
  logic        r_wrl_q;
  logic        r_wrh_q;
  logic [22:0] r_a_q;

  // FSM and SDRAM channel registers.
  state_t      r_state;
  logic        r_mem_req;
  logic [23:0] r_mem_addr;
  logic [15:0] r_mem_do;
  logic [1:0]  r_mem_be;
  logic        r_mem_we;
  logic [22:0] r_req_a;

  // Mapper-side return registers.
  logic [15:0] r_rom_di;
  logic        r_rdy;
  logic        r_wack;

  // One-word read cache.
  logic        r_tag_vld;
  logic [22:0] r_tag;
  logic [15:0] r_cache_d;

  // Events held while a request is outstanding.
  logic        r_pend_rd;
  logic        r_pend_wr;
  logic [22:0] r_pw_a;
  logic [15:0] r_pw_d;
  logic [1:0]  r_pw_be;

  logic        w_a_chg;
  logic        w_rd_evt;
  logic        w_wr_evt;
  logic        w_stale;
  logic        w_done;
  logic        w_idle_go;
  logic        w_wr_take;
  logic        w_rd_want;
  logic        w_rd_take;
  logic        w_hit;
  logic [22:0] w_wr_a;
  logic [15:0] w_wr_d;
  logic [1:0]  w_wr_be;
  logic [15:0] w_merge;
  logic [23:0] w_rd_mem_addr;
  logic [23:0] w_wr_mem_addr;

  // A read event is a rising ROM_RD or an address change while ROM_RD is
  // held. A write event is the first cycle of either byte strobe.
  assign w_a_chg  = (ROM_A != r_a_q);
  assign w_rd_evt = ROM_RD & (~r_rd_q | w_a_chg);
  assign w_wr_evt = (ROM_WRL | ROM_WRH) & ~(r_wrl_q | r_wrh_q);

  // A request is outstanding while REQ and ACK differ. The request has
  // completed when they match again.
  assign w_done  = (r_mem_req == MEM_ACK);
  assign w_stale = ~w_done;

  // IDLE issues nothing while a late ACK from before a reset is still being
  // absorbed. Otherwise a write (new or held) wins over a read.
  assign w_idle_go = (r_state == S_IDLE) & ~w_stale;
  assign w_wr_take = w_idle_go & (r_pend_wr | w_wr_evt);
  assign w_rd_want = w_rd_evt | (r_pend_rd & ROM_RD);
  assign w_rd_take = w_idle_go & ~(r_pend_wr | w_wr_evt) & w_rd_want;

  // A read always targets the current ROM_A. Any older address has lost
  // interest by the time the read is serviced.
  assign w_hit         = r_tag_vld & (r_tag == ROM_A);
  assign w_rd_mem_addr = BASE_WORD + {1'b0, ROM_A};
  assign w_wr_mem_addr = BASE_WORD + {1'b0, w_wr_a};

  // Select the write source (held slot first) and build the coherent cache
  // word from the outstanding write's enabled bytes.
  // NOTE: every output of an always_comb gets a default before any branch,
  // so no path can leave a value unassigned and infer a latch.
  always_comb begin
    w_wr_a  = ROM_A;
    w_wr_d  = ROM_DO;
    w_wr_be = {ROM_WRH, ROM_WRL};
    if (r_pend_wr) begin
      w_wr_a  = r_pw_a;
      w_wr_d  = r_pw_d;
      w_wr_be = r_pw_be;
    end
    w_merge = r_cache_d;
    if (r_mem_be[1]) w_merge[15:8] = r_mem_do[15:8];
    if (r_mem_be[0]) w_merge[7:0]  = r_mem_do[7:0];
  end

  // Register the strobes and address for event detection.
  // NOTE: state uses non-blocking assignments only. All flops then sample
  // pre-edge values, whatever order the simulator evaluates the blocks in.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rd_q  <= 1'b0;
      r_wrl_q <= 1'b0;
      r_wrh_q <= 1'b0;
      r_a_q   <= '0;
    end else begin
      r_rd_q  <= ROM_RD;
      r_wrl_q <= ROM_WRL;
      r_wrh_q <= ROM_WRH;
      r_a_q   <= ROM_A;
    end
  end

  // Hold events that the FSM cannot service this cycle. A newer event of
  // the same kind replaces the held one.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pend_rd <= 1'b0;
      r_pend_wr <= 1'b0;
      r_pw_a    <= '0;
      r_pw_d    <= '0;
      r_pw_be   <= '0;
    end else begin
      if (w_wr_evt && !(w_wr_take && !r_pend_wr)) begin
        r_pend_wr <= 1'b1;
        r_pw_a    <= ROM_A;
        r_pw_d    <= ROM_DO;
        r_pw_be   <= {ROM_WRH, ROM_WRL};
      end else if (w_wr_take) begin
        r_pend_wr <= 1'b0;
      end

      if (w_rd_take) begin
        r_pend_rd <= 1'b0;
      end else begin
        r_pend_rd <= (r_pend_rd & ROM_RD) | w_rd_evt;
      end
    end
  end

  // Main FSM: issue requests, retire completions, and maintain the cache
  // and the mapper-side flags.
  // NOTE: the one-word cache is reset along with everything else. Hits
  // still depend only on r_tag_vld, so the data reset is just for hygiene.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_mem_req  <= MEM_ACK;
      r_mem_addr <= '0;
      r_mem_do   <= '0;
      r_mem_be   <= '0;
      r_mem_we   <= 1'b0;
      r_req_a    <= '0;
      r_rom_di   <= '0;
      r_rdy      <= 1'b0;
      r_wack     <= 1'b0;
      r_tag_vld  <= 1'b0;
      r_tag      <= '0;
      r_cache_d  <= '0;
    end else begin
      r_wack <= 1'b0;
      // Ready belongs to one address only: drop it on a falling read or an
      // address change. The branches below may set it again for the new
      // address.
      if (!ROM_RD || w_a_chg) r_rdy <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_stale) begin
            r_mem_req <= MEM_ACK;
          end else if (w_wr_take) begin
            if (WR_EN) begin
              r_mem_addr <= w_wr_mem_addr;
              r_mem_do   <= w_wr_d;
              r_mem_be   <= w_wr_be;
              r_mem_we   <= 1'b1;
              r_mem_req  <= ~r_mem_req;
              r_req_a    <= w_wr_a;
              r_state    <= S_WR_WAIT;
            end else begin
              r_wack <= 1'b1;
            end
          end else if (w_rd_take) begin
            if (w_hit) begin
              r_rom_di <= r_cache_d;
              r_rdy    <= 1'b1;
            end else begin
              r_rdy      <= 1'b0;
              r_mem_addr <= w_rd_mem_addr;
              r_mem_be   <= 2'b11;
              r_mem_we   <= 1'b0;
              r_mem_req  <= ~r_mem_req;
              r_req_a    <= ROM_A;
              r_state    <= S_RD_WAIT;
            end
          end
        end

        S_RD_WAIT: begin
          if (w_done) begin
            r_rom_di  <= MEM_DI;
            r_cache_d <= MEM_DI;
            r_tag     <= r_req_a;
            r_tag_vld <= 1'b1;
            r_rdy     <= ROM_RD && (ROM_A == r_req_a);
            r_state   <= S_IDLE;
          end
        end

        S_WR_WAIT: begin
          if (w_done) begin
            r_wack <= 1'b1;
            if (r_tag_vld && (r_tag == r_req_a)) r_cache_d <= w_merge;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ROM_DI   = r_rom_di;
  assign ROM_RDY  = r_rdy;
  assign ROM_WACK = r_wack;
  assign MEM_ADDR = r_mem_addr;
  assign MEM_DO   = r_mem_do;
  assign MEM_BE   = r_mem_be;
  assign MEM_WE   = r_mem_we;
  assign MEM_REQ  = r_mem_req;

endmodule

// File: tb/tb_cart_rom_port.sv
// tb_cart_rom_port
// Directed bench for cart_rom_port. One instance forwards writes and uses a
// 0x400000 byte base. A second instance discards writes and uses a base
// close to the top of the address space, so its address wraps. Each
// instance has its own SDRAM responder, which acks after a set number of
// cycles.

module tb_cart_rom_port;

  logic        CLK = 1'b0;
  logic        rst_n;

  // Instance with writes forwarded.
  logic [22:0] rom_a;
  logic [15:0] rom_do;
  logic        rom_rd, rom_wrl, rom_wrh;
  logic [15:0] rom_di;
  logic        rom_rdy, rom_wack;
  logic [23:0] mem_addr;
  logic [15:0] mem_do;
  logic [1:0]  mem_be;
  logic        mem_we, mem_req, mem_ack;
  logic [15:0] mem_di;

  // Instance with writes discarded.
  logic [22:0] rom_a_0;
  logic [15:0] rom_do_0;
  logic        rom_rd_0, rom_wrl_0, rom_wrh_0;
  logic [15:0] rom_di_0;
  logic        rom_rdy_0, rom_wack_0;
  logic [23:0] mem_addr_0;
  logic [15:0] mem_do_0;
  logic [1:0]  mem_be_0;
  logic        mem_we_0, mem_req_0, mem_ack_0;
  logic [15:0] mem_di_0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 CLK = ~CLK;

  cart_rom_port #(.BASE_ADDR(25'h0400000), .WR_EN(1'b1)) dut (
    .CLK(CLK), .RST_N(rst_n),
    .ROM_A(rom_a), .ROM_DO(rom_do), .ROM_RD(rom_rd),
    .ROM_WRL(rom_wrl), .ROM_WRH(rom_wrh),
    .ROM_DI(rom_di), .ROM_RDY(rom_rdy), .ROM_WACK(rom_wack),
    .MEM_ADDR(mem_addr), .MEM_DO(mem_do), .MEM_BE(mem_be), .MEM_WE(mem_we),
    .MEM_REQ(mem_req), .MEM_ACK(mem_ack), .MEM_DI(mem_di)
  );

  cart_rom_port #(.BASE_ADDR(25'h1FFFFFF), .WR_EN(1'b0)) dut0 (
    .CLK(CLK), .RST_N(rst_n),
    .ROM_A(rom_a_0), .ROM_DO(rom_do_0), .ROM_RD(rom_rd_0),
    .ROM_WRL(rom_wrl_0), .ROM_WRH(rom_wrh_0),
    .ROM_DI(rom_di_0), .ROM_RDY(rom_rdy_0), .ROM_WACK(rom_wack_0),
    .MEM_ADDR(mem_addr_0), .MEM_DO(mem_do_0), .MEM_BE(mem_be_0), .MEM_WE(mem_we_0),
    .MEM_REQ(mem_req_0), .MEM_ACK(mem_ack_0), .MEM_DI(mem_di_0)
  );

  // SDRAM responders: once a request has been pending for rsp_delay falling
  // edges, drive the data and toggle ACK.
  int          rsp_delay = 3;
  logic [15:0] rsp_data  = 16'h0000;
  bit          rsp_hold  = 1'b0;
  int          rsp_cnt   = 0;
  logic [15:0] rsp0_data = 16'h0000;
  int          rsp0_cnt  = 0;

  initial begin
    forever begin
      @(negedge CLK);
      if (rsp_hold || (mem_req == mem_ack)) begin
        rsp_cnt = 0;
      end else begin
        rsp_cnt++;
        if (rsp_cnt >= rsp_delay) begin
          mem_di  = rsp_data;
          mem_ack = ~mem_ack;
          rsp_cnt = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (mem_req_0 == mem_ack_0) begin
        rsp0_cnt = 0;
      end else begin
        rsp0_cnt++;
        if (rsp0_cnt >= 2) begin
          mem_di_0  = rsp0_data;
          mem_ack_0 = ~mem_ack_0;
          rsp0_cnt  = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One read on the forwarding instance. ROM_RD is dropped for a cycle
  // first, then raised at address a. On a miss, a request to ea must follow
  // and RDY must appear dly+1 cycles after the strobe. On a hit, no request
  // may toggle and RDY must appear 1 cycle after the strobe.
  task automatic do_read(input string tag, input logic [22:0] a, input int dly,
                         input logic [15:0] d, input bit hit,
                         input logic [23:0] ea, input logic [15:0] ed);
    logic req0;
    int   n;
    bit   done;
    rom_rd = 1'b0;
    @(negedge CLK);
    check($sformatf("%s/rdy_drop", tag), {31'd0, rom_rdy}, 32'd0);
    rsp_delay = dly;
    rsp_data  = d;
    req0      = mem_req;
    rom_a     = a;
    rom_rd    = 1'b1;
    n    = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge CLK);
      n++;
      if (n == 1) begin
        check($sformatf("%s/req_toggle", tag), {31'd0, mem_req ^ req0}, {31'd0, !hit});
        if (!hit) begin
          check($sformatf("%s/mem_addr", tag), {8'd0, mem_addr}, {8'd0, ea});
          check($sformatf("%s/mem_we", tag), {31'd0, mem_we}, 32'd0);
          check($sformatf("%s/mem_be", tag), {30'd0, mem_be}, 32'd3);
        end
      end
      done = rom_rdy;
    end
    check($sformatf("%s/latency", tag), n, hit ? 32'd1 : dly + 1);
    check($sformatf("%s/rom_di", tag), {16'd0, rom_di}, {16'd0, ed});
  endtask

  typedef struct {
    logic [22:0] a;
    int          dly;
    logic [15:0] data;
    bit          hit;
    logic [23:0] exp_addr;
    logic [15:0] exp_di;
  } rd_vec_t;

  rd_vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic req0;
    int   n;
    bit   done;
    int   wack_cnt;
    int   wack_first;

    vecs[0] = '{23'h000010, 5, 16'hBEEF, 1'b0, 24'h200010, 16'hBEEF};
    vecs[1] = '{23'h000010, 2, 16'h0000, 1'b1, 24'h000000, 16'hBEEF};
    vecs[2] = '{23'h000011, 3, 16'h1234, 1'b0, 24'h200011, 16'h1234};
    vecs[3] = '{23'h000011, 2, 16'h0000, 1'b1, 24'h000000, 16'h1234};
    vecs[4] = '{23'h7FFFFF, 2, 16'h5A5A, 1'b0, 24'h9FFFFF, 16'h5A5A};
    vecs[5] = '{23'h000010, 4, 16'hBEEF, 1'b0, 24'h200010, 16'hBEEF};

    rst_n   = 1'b0;
    rom_a   = '0; rom_do   = '0; rom_rd   = 1'b0; rom_wrl   = 1'b0; rom_wrh   = 1'b0;
    rom_a_0 = '0; rom_do_0 = '0; rom_rd_0 = 1'b0; rom_wrl_0 = 1'b0; rom_wrh_0 = 1'b0;
    mem_ack   = 1'b1;
    mem_di    = '0;
    mem_ack_0 = 1'b0;
    mem_di_0  = '0;

    // Reset state. REQ must follow ACK, which is deliberately 1 here.
    repeat (3) @(negedge CLK);
    check("rst/rom_di",   {16'd0, rom_di}, 32'd0);
    check("rst/rom_rdy",  {31'd0, rom_rdy}, 32'd0);
    check("rst/rom_wack", {31'd0, rom_wack}, 32'd0);
    check("rst/mem_addr", {8'd0, mem_addr}, 32'd0);
    check("rst/mem_do",   {16'd0, mem_do}, 32'd0);
    check("rst/mem_be",   {30'd0, mem_be}, 32'd0);
    check("rst/mem_we",   {31'd0, mem_we}, 32'd0);
    check("rst/mem_req",  {31'd0, mem_req}, 32'd1);
    check("rst/mem_req_0", {31'd0, mem_req_0}, 32'd0);
    rst_n = 1'b1;
    @(negedge CLK);

    // Table of reads: misses, hits, top-of-range address.
    for (int i = 0; i < 6; i++) begin
      do_read($sformatf("vec%0d", i), vecs[i].a, vecs[i].dly, vecs[i].data,
              vecs[i].hit, vecs[i].exp_addr, vecs[i].exp_di);
    end

    // High-byte write to the cached word 0x10 (holding BEEF).
    rom_rd  = 1'b0;
    rom_a   = 23'h000010;
    rom_do  = 16'h12AB;
    rom_wrh = 1'b1;
    rom_wrl = 1'b0;
    rsp_delay  = 3;
    req0       = mem_req;
    wack_cnt   = 0;
    wack_first = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      if (i == 1) begin
        check("wr/req_toggle", {31'd0, mem_req ^ req0}, 32'd1);
        check("wr/mem_be",   {30'd0, mem_be}, 32'd2);
        check("wr/mem_we",   {31'd0, mem_we}, 32'd1);
        check("wr/mem_addr", {8'd0, mem_addr}, 32'h200010);
        check("wr/mem_do",   {16'd0, mem_do}, 32'h12AB);
      end
      if (rom_wack) begin
        wack_cnt++;
        if (wack_first == 0) wack_first = i;
      end
      if (i == 6) rom_wrh = 1'b0;
    end
    check("wr/wack_count", wack_cnt, 32'd1);
    check("wr/wack_cycle", wack_first, 32'd4);
    do_read("wr_reread", 23'h000010, 2, 16'h0000, 1'b1, 24'h000000, 16'h12EF);

    // Address change while a read is in flight.
    do_read("evict", 23'h7FFFFF, 2, 16'h5A5A, 1'b0, 24'h9FFFFF, 16'h5A5A);
    rom_rd = 1'b0;
    @(negedge CLK);
    rom_a     = 23'h000010;
    rom_rd    = 1'b1;
    rsp_delay = 4;
    rsp_data  = 16'h1111;
    n    = 0;
    done = 1'b0;
    while (!done && n < 30) begin
      @(negedge CLK);
      n++;
      if (n == 1) check("achg/addr1", {8'd0, mem_addr}, 32'h200010);
      if (n == 2) rom_a = 23'h000020;
      if (n == 5) begin
        check("achg/rdy_after_first", {31'd0, rom_rdy}, 32'd0);
        check("achg/first_done", {31'd0, mem_req ^ mem_ack}, 32'd0);
        rsp_data = 16'h2222;
      end
      if (n == 6) begin
        check("achg/addr2", {8'd0, mem_addr}, 32'h200020);
        check("achg/second_pending", {31'd0, mem_req ^ mem_ack}, 32'd1);
      end
      done = rom_rdy;
    end
    check("achg/latency", n, 32'd10);
    check("achg/rom_di", {16'd0, rom_di}, 32'h2222);

    // Discarding instance: wrapped address, dropped write, cache unchanged.
    rom_a_0   = 23'h000002;
    rom_rd_0  = 1'b1;
    rsp0_data = 16'h7777;
    req0      = mem_req_0;
    n    = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge CLK);
      n++;
      if (n == 1) begin
        check("nowr/mem_addr_wrap", {8'd0, mem_addr_0}, 32'h000001);
        check("nowr/req_toggle", {31'd0, mem_req_0 ^ req0}, 32'd1);
      end
      done = rom_rdy_0;
    end
    check("nowr/latency", n, 32'd3);
    check("nowr/rom_di", {16'd0, rom_di_0}, 32'h7777);
    rom_rd_0  = 1'b0;
    rom_wrl_0 = 1'b1;
    rom_do_0  = 16'hAAAA;
    req0      = mem_req_0;
    @(negedge CLK);
    check("nowr/wack_pulse", {31'd0, rom_wack_0}, 32'd1);
    check("nowr/no_req", {31'd0, mem_req_0 ^ req0}, 32'd0);
    rom_wrl_0 = 1'b0;
    @(negedge CLK);
    check("nowr/wack_end", {31'd0, rom_wack_0}, 32'd0);
    rom_rd_0 = 1'b1;
    @(negedge CLK);
    check("nowr/hit_rdy", {31'd0, rom_rdy_0}, 32'd1);
    check("nowr/hit_data", {16'd0, rom_di_0}, 32'h7777);
    check("nowr/hit_no_req", {31'd0, mem_req_0 ^ req0}, 32'd0);

    // One-cycle reset while a read is outstanding and never acked.
    rom_rd = 1'b0;
    @(negedge CLK);
    rom_a    = 23'h000030;
    rom_rd   = 1'b1;
    rsp_hold = 1'b1;
    req0     = mem_req;
    @(negedge CLK);
    check("rstmid/req_toggle", {31'd0, mem_req ^ req0}, 32'd1);
    @(negedge CLK);
    rst_n = 1'b0;
    @(negedge CLK);
    rst_n  = 1'b1;
    rom_rd = 1'b0;
    check("rstmid/req_eq_ack", {31'd0, mem_req ^ mem_ack}, 32'd0);
    check("rstmid/rdy", {31'd0, rom_rdy}, 32'd0);
    check("rstmid/rom_di", {16'd0, rom_di}, 32'd0);
    rsp_hold = 1'b0;
    do_read("rstmid_miss", 23'h000020, 3, 16'h3333, 1'b0, 24'h200020, 16'h3333);
    do_read("rstmid_hit", 23'h000020, 2, 16'h0000, 1'b1, 24'h000000, 16'h3333);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
